quad_encoder_input: RTL
=======================

// Module: quad_encoder_input
// PURPOSE
//  Front-end for the LCD status display: conditions the raw rotary-encoder pair and push switch, then decodes detents.
//  Maintains a wrapping detent counter and emits one-cycle step and switch-press strobes.
//  The LCD writer consumes value, changed, sw_level and sw_press to schedule repaints; it does no decoding itself.
// PARAMETERS
//  SAMPLE_DIV  256  clk cycles between input samples; legal range >= 2
//  DEB_CNT     4    consecutive equal samples needed to accept a new level; legal range >= 1
//  VAL_W       8    width of the detent counter
// PORTS
//  clk       in   1      system clock
//  reset     in   1      synchronous, active-high reset
//  enc       in   2      raw encoder phases {B,A}, asynchronous; 00 = detent rest
//  d_sw      in   1      raw push switch, asynchronous, active-low (0 = pressed)
//  clr       in   1      synchronous counter clear
//  value     out  VAL_W  detent count, wraps modulo 2^VAL_W
//  step_up   out  1      1-cycle pulse when a CW detent completes
//  step_dn   out  1      1-cycle pulse when a CCW detent completes
//  changed   out  1      1-cycle pulse whenever value changes for any reason (step or clr)
//  sw_level  out  1      debounced switch level, 1 = pressed
//  sw_press  out  1      1-cycle pulse on the debounced press edge
// BEHAVIOUR
//  Reset: value=0, all pulses=0, sw_level=0, FSM=REST, filtered enc=00, divider=0, debounce counts=0.
//  Synchroniser: enc and d_sw each pass through 2 clk flops before any further logic.
//  Divider: free-running 0..SAMPLE_DIV-1; tick asserts for 1 cycle when divider = SAMPLE_DIV-1.
//  Debounce (per bit, evaluated on tick only):
//  - sample == filtered: count := 0.
//  - sample != filtered: count++; at DEB_CNT the filtered bit takes the sample and count := 0.
//  - DEB_CNT=1 accepts a change on the first differing tick.
//  FSM on filtered enc, evaluated in the cycle after the filtered value updates; one transition per update.
//  - REST: 01->CW1, 10->CCW1, 11->ERR.
//  - CW1:  00->REST (no count), 11->CW2, 10->ERR.
//  - CW2:  10->CW3, 01->CW1, 00->ERR.
//  - CW3:  00->REST with +1 and step_up, 11->CW2, 01->ERR.
//  - CCW1: 00->REST (no count), 11->CCW2, 01->ERR.
//  - CCW2: 01->CCW3, 10->CCW1, 00->ERR.
//  - CCW3: 00->REST with -1 and step_dn, 11->CCW2, 10->ERR.
//  - ERR:  00->REST with no count; any other code stays in ERR.
//  Mid-cycle reversal returns to REST without a count.
//  Both filtered bits changing on the same tick count as a jump and take the ERR arc listed above.
//  Arithmetic: value +/- 1 modulo 2^VAL_W. Examples: 255+1=0, 0-1=255 (VAL_W=8).
//  Outputs are registered. value and its strobe change in the same cycle.
//  clr: value:=0 next cycle and pulses changed; the FSM state is unaffected.
//  - clr in the same cycle as a completed detent: clr wins, no step pulse.
//  - clr when value is already 0: no changed pulse.
//  Switch: sw_level = ~filtered d_sw. sw_press pulses for 1 cycle on its 0->1 transition; no pulse on release.
//  reset mid-detent: all state is dropped and the FSM restarts in REST; a partial rotation never counts.
//  Latency, raw edge to pulse: 2 sync cycles, plus up to SAMPLE_DIV*DEB_CNT cycles, plus 1 cycle.
// STRUCTURE
//  Shared package lcd_ui_pkg:
//  - enc_state_t enum {REST,CW1,CW2,CW3,CCW1,CCW2,CCW3,ERR}.
//  - Constants ENC_REST=2'b00 and SW_ACTIVE_LOW=1.
//  Sub-module debounce_bit:
//  - Parameter DEB_CNT; ports clk, reset, tick, din, dout.
//  - Instantiated 3x (enc[0], enc[1], d_sw). Synchroniser, divider, FSM and counter stay in this module.
// TESTING (bench uses SAMPLE_DIV=4, DEB_CNT=2)
//  - CW sequence 00->01->11->10->00, each code held 16 clk -> exactly one step_up and one changed; value 0->1; no step_dn.
//  - CCW detent from value=0 -> value=255 with one step_dn. Then 256 CW detents -> value=255 again (wrap both ways).
//  - Partial rotation 00->01->11->01->00 -> no pulses, value unchanged, FSM back in REST.
//  - Jump 00->11->00 -> no count. Glitch on enc[0] held only 1 tick -> filtered enc and value unchanged.
//  - d_sw bouncing 1/0/1/0 every 2 clk, then held 0 for 16 clk -> single sw_press, sw_level=1; release -> sw_level=0, no pulse.
//  - clr coincident with a completing CW detent at value=7 -> value=0, one changed, no step_up.
//  - reset asserted while in CW2 -> value=0 and REST next cycle; the following 10->00 yields no count.

Source files
------------

// File: rtl/lcd_ui_pkg.sv
// rtl/lcd_ui_pkg.sv - shared types and constants for the LCD user-input front-end
package lcd_ui_pkg;

  typedef enum logic [2:0] {REST, CW1, CW2, CW3, CCW1, CCW2, CCW3, ERR} enc_state_t;

  localparam logic [1:0] ENC_REST      = 2'b00;
  localparam logic       SW_ACTIVE_LOW = 1'b1;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - per-bit debouncer, accepts a new level after DEB_CNT differing ticks
module debounce_bit #(
  parameter int   DEB_CNT = 4,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(DEB_CNT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;

  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (tick) begin
      if (din == dout_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEB_CNT - 1)) begin
        dout_d = din;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      dout_q <= RST_VAL;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/quad_encoder_input.sv
// rtl/quad_encoder_input.sv - rotary encoder and push-switch conditioning with detent counter
module quad_encoder_input
  import lcd_ui_pkg::*;
#(
  parameter int SAMPLE_DIV = 256,
  parameter int DEB_CNT    = 4,
  parameter int VAL_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       enc,
  input  logic             d_sw,
  input  logic             clr,
  output logic [VAL_W-1:0] value,
  output logic             step_up,
  output logic             step_dn,
  output logic             changed,
  output logic             sw_level,
  output logic             sw_press
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);

  logic [1:0]       enc_s1_q, enc_s2_q, enc_f, enc_last_q;
  logic             sw_s1_q, sw_s2_q, sw_f;
  logic [DIV_W-1:0] div_q;
  logic             tick;
  enc_state_t       state_q, state_d;
  logic             inc, dec;
  logic [VAL_W-1:0] value_q, value_d;
  logic             up_q, up_d, dn_q, dn_d, chg_q, chg_d;
  logic             lvl_q, lvl_d, press_q, press_d;

  assign tick = (div_q == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      enc_s1_q   <= ENC_REST;
      enc_s2_q   <= ENC_REST;
      sw_s1_q    <= SW_ACTIVE_LOW;
      sw_s2_q    <= SW_ACTIVE_LOW;
      div_q      <= '0;
      enc_last_q <= ENC_REST;
    end else begin
      enc_s1_q   <= enc;
      enc_s2_q   <= enc_s1_q;
      sw_s1_q    <= d_sw;
      sw_s2_q    <= sw_s1_q;
      div_q      <= tick ? '0 : div_q + DIV_W'(1);
      enc_last_q <= enc_f;
    end
  end

  debounce_bit #(.DEB_CNT(DEB_CNT), .RST_VAL(1'b0)) u_deb_a (
    .clk(clk), .reset(reset), .tick(tick), .din(enc_s2_q[0]), .dout(enc_f[0]));
  debounce_bit #(.DEB_CNT(DEB_CNT), .RST_VAL(1'b0)) u_deb_b (
    .clk(clk), .reset(reset), .tick(tick), .din(enc_s2_q[1]), .dout(enc_f[1]));
  debounce_bit #(.DEB_CNT(DEB_CNT), .RST_VAL(SW_ACTIVE_LOW)) u_deb_sw (
    .clk(clk), .reset(reset), .tick(tick), .din(sw_s2_q), .dout(sw_f));

  // One FSM step per change of the filtered code, seen one cycle after it lands.
  always_comb begin
    state_d = state_q;
    inc     = 1'b0;
    dec     = 1'b0;
    if (enc_f != enc_last_q) begin
      case (state_q)
        REST: case (enc_f)
          2'b01:   state_d = CW1;
          2'b10:   state_d = CCW1;
          2'b11:   state_d = ERR;
          default: state_d = REST;
        endcase
        CW1: case (enc_f)
          ENC_REST: state_d = REST;
          2'b11:    state_d = CW2;
          2'b10:    state_d = ERR;
          default:  state_d = CW1;
        endcase
        CW2: case (enc_f)
          2'b10:    state_d = CW3;
          2'b01:    state_d = CW1;
          ENC_REST: state_d = ERR;
          default:  state_d = CW2;
        endcase
        CW3: case (enc_f)
          ENC_REST: begin state_d = REST; inc = 1'b1; end
          2'b11:    state_d = CW2;
          2'b01:    state_d = ERR;
          default:  state_d = CW3;
        endcase
        CCW1: case (enc_f)
          ENC_REST: state_d = REST;
          2'b11:    state_d = CCW2;
          2'b01:    state_d = ERR;
          default:  state_d = CCW1;
        endcase
        CCW2: case (enc_f)
          2'b01:    state_d = CCW3;
          2'b10:    state_d = CCW1;
          ENC_REST: state_d = ERR;
          default:  state_d = CCW2;
        endcase
        CCW3: case (enc_f)
          ENC_REST: begin state_d = REST; dec = 1'b1; end
          2'b11:    state_d = CCW2;
          2'b10:    state_d = ERR;
          default:  state_d = CCW3;
        endcase
        ERR:     state_d = (enc_f == ENC_REST) ? REST : ERR;
        default: state_d = REST;
      endcase
    end
  end

  // clr takes priority over a completing detent and suppresses its step strobe.
  always_comb begin
    value_d = value_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    chg_d   = 1'b0;
    if (clr) begin
      value_d = '0;
      chg_d   = |value_q;
    end else if (inc) begin
      value_d = value_q + VAL_W'(1);
      up_d    = 1'b1;
      chg_d   = 1'b1;
    end else if (dec) begin
      value_d = value_q - VAL_W'(1);
      dn_d    = 1'b1;
      chg_d   = 1'b1;
    end
    lvl_d   = SW_ACTIVE_LOW ? ~sw_f : sw_f;
    press_d = lvl_d & ~lvl_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= REST;
      value_q <= '0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      chg_q   <= 1'b0;
      lvl_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      chg_q   <= chg_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
    end
  end

  assign value    = value_q;
  assign step_up  = up_q;
  assign step_dn  = dn_q;
  assign changed  = chg_q;
  assign sw_level = lvl_q;
  assign sw_press = press_q;

endmodule
